nibble_serial_add_ctrl: RTL and testbench
=========================================

NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand width in bits; legal values are multiples of 4 from 8 to 64.
REQ-002 SHALL have derived constant NIBBLES, equal to WIDTH/4: the number of adder passes per operation.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: operands and carry-in are valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts operands.
REQ-007 SHALL have port a, input, WIDTH bits: operand A.
REQ-008 SHALL have port b, input, WIDTH bits: operand B.
REQ-009 SHALL have port cin, input, 1 bit: carry-in to nibble 0.
REQ-010 SHALL have port op, input, 1 bit: 0 selects add, 1 selects subtract; present only with SUB_EN.
REQ-011 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 SHALL have port sum, output, WIDTH bits: the result.
REQ-014 SHALL have port cout, output, 1 bit: carry-out of the most significant nibble.

Function
REQ-015 SHALL compute {cout,sum} = a + b + cin, modulo 2^(WIDTH+1), using one 4-bit adder slice reused once per nibble (time-multiplexed), least-significant nibble first.
REQ-016 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-017 SHALL drive in_ready = 1 only in IDLE.
REQ-018 SHALL, on an accept (in_valid & in_ready at edge T): register a, b and cin, set the nibble counter to 0, and go to RUN.
REQ-019 SHALL, in RUN, process nibble k = counter each cycle: feed a[4k+3:4k], b[4k+3:4k] and the carry register to the slice; write the slice sum into sum[4k+3:4k]; load the slice carry-out into the carry register; increment the counter.
REQ-020 SHALL go from RUN to DONE after the edge that processes nibble NIBBLES-1; out_valid rises in the cycle after edge T+NIBBLES (latency NIBBLES+1 cycles from accept to out_valid).
REQ-021 SHALL, in DONE, hold out_valid = 1 with sum and cout stable until out_valid & out_ready, then return to IDLE; no new accept occurs in the same cycle.
REQ-022 SHALL ignore in_valid, a, b and cin outside IDLE; the operands are captured only at accept.
REQ-023 SHALL assert cout equal to the final carry register; cout is meaningful only while out_valid = 1.
REQ-024 SHALL hold the nibble counter at $clog2(NIBBLES) bits with no wrap beyond NIBBLES-1.
REQ-025 SHALL keep sum and cout stable while out_valid is low (not updated during RUN).

Reset
REQ-026 SHALL, while rst_n = 0 (asynchronous): state = IDLE, in_ready = 1, out_valid = 0, sum = 0, cout = 0, counter = 0, carry register = 0.
REQ-027 SHALL, on reset asserted mid-RUN or in DONE, abort the operation immediately with no output pulse; the first accept is possible on the first edge after rst_n deasserts.

Configuration
REQ-028 SHALL support macro NIBBLE_SERIAL_SUB_EN; when defined, the op port exists and op = 1 captured at accept computes a - b as a + ~b + 1: cin is ignored, cout = 1 means no borrow.
REQ-029 SHALL, when NIBBLE_SERIAL_SUB_EN is undefined, have no op port, and the block behaves as add-only.

Structure
REQ-030 SHALL place the FSM state typedef (IDLE/RUN/DONE) and the NIBBLE_W = 4 constant in the shared package nibble_serial_pkg.
REQ-031 SHALL instantiate exactly one sub-module, add4_slice: purely combinational, inputs a[3:0], b[3:0], cin; outputs sum[3:0], cout.

Verification (WIDTH = 16)
REQ-032 SHALL cover: a = 0x1234, b = 0x1111, cin = 0 -> sum = 0x2345, cout = 0, with out_valid first high 5 cycles after accept.
REQ-033 SHALL cover: a = 0xFFFF, b = 0x0001, cin = 0 -> sum = 0x0000, cout = 1 (carry ripples through all 4 passes); a = 0xFFFF, b = 0x0000, cin = 1 -> same result.
REQ-034 SHALL cover: out_ready held 0 for 3 cycles in DONE -> out_valid, sum and cout stable, in_ready = 0; in_valid pulsed with new operands is ignored; after handshake, in_ready = 1 next cycle.
REQ-035 SHALL cover: rst_n asserted after 2 RUN cycles -> out_valid = 0, in_ready = 1 and sum = 0 at once; the next operation 0x00FF + 0x0001 yields 0x0100, cout = 0.
REQ-036 SHALL cover, with NIBBLE_SERIAL_SUB_EN: op = 1, a = 0x0005, b = 0x0007 -> sum = 0xFFFE, cout = 0; a = 0x0007, b = 0x0005 -> sum = 0x0002, cout = 1.
REQ-037 SHALL cover: back-to-back transactions with out_ready tied to 1 -> one result every NIBBLES + 2 cycles.

Source files
------------

// File: rtl/nibble_serial_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
package nibble_serial_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/add4_slice.sv
// Combinational 4-bit adder slice, reused once per nibble by the controller.
module add4_slice
  import nibble_serial_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [NIBBLE_W:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};
  assign sum   = total[NIBBLE_W-1:0];
  assign cout  = total[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Time-multiplexed WIDTH-bit adder: one 4-bit slice processes one nibble per cycle, LSB first.
// Optional subtract mode (op port) is enabled by defining NIBBLE_SERIAL_SUB_EN.
module nibble_serial_add_ctrl
  import nibble_serial_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef NIBBLE_SERIAL_SUB_EN
  input  logic             op,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CNT_W   = $clog2(NIBBLES);

  state_t state, state_next;

  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  logic             cout_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [WIDTH-1:0]    b_eff;
  logic                cin_eff;
  logic [WIDTH-1:0]    acc_merged;
  logic [NIBBLE_W-1:0] a_nib [NIBBLES];
  logic [NIBBLE_W-1:0] b_nib [NIBBLES];
  logic [NIBBLE_W-1:0] slice_a, slice_b, slice_sum;
  logic                slice_cout;
  logic                accept;
  logic                last_nib;

`ifdef NIBBLE_SERIAL_SUB_EN
  // Subtraction as a + ~b + 1; the caller's cin is deliberately ignored in that mode.
  assign b_eff   = op ? ~b : b;
  assign cin_eff = op ? 1'b1 : cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  assign accept   = in_valid & in_ready;
  assign last_nib = (cnt_reg == CNT_W'(NIBBLES - 1));

  // Per-nibble views of the operands, and the accumulator with the current slice result merged in.
  for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
    assign a_nib[gi] = a_reg[gi*NIBBLE_W +: NIBBLE_W];
    assign b_nib[gi] = b_reg[gi*NIBBLE_W +: NIBBLE_W];
    assign acc_merged[gi*NIBBLE_W +: NIBBLE_W] =
      (cnt_reg == CNT_W'(gi)) ? slice_sum : acc_reg[gi*NIBBLE_W +: NIBBLE_W];
  end

  assign slice_a = a_nib[cnt_reg];
  assign slice_b = b_nib[cnt_reg];

  add4_slice u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_reg),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last_nib) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Partial sums build up in acc_reg; the visible result only changes once the last nibble lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else if (accept) begin
      a_reg     <= a;
      b_reg     <= b_eff;
      carry_reg <= cin_eff;
      cnt_reg   <= '0;
    end else if (state == RUN) begin
      acc_reg   <= acc_merged;
      carry_reg <= slice_cout;
      if (last_nib) begin
        sum_reg  <= acc_merged;
        cout_reg <= slice_cout;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed, table-driven bench for nibble_serial_add_ctrl (WIDTH = 16); subtract vectors
// are added when NIBBLE_SERIAL_SUB_EN is defined.
module tb_nibble_serial_add_ctrl;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             op;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_cout;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
`ifdef NIBBLE_SERIAL_SUB_EN
  logic             op = 1'b0;
`endif
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int               n_cmp = 0;
  int               n_fail = 0;
  logic [WIDTH-1:0] prev_sum = '0;
  vec_t             vecs[$];

  always #5 clk = ~clk;

  nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef NIBBLE_SERIAL_SUB_EN
    .op        (op),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic vcin,
                         input logic vop, input logic [WIDTH-1:0] es, input logic ec);
    vec_t v;
    v.a = va; v.b = vb; v.cin = vcin; v.op = vop; v.exp_sum = es; v.exp_cout = ec;
    vecs.push_back(v);
  endtask

  // One full transaction with out_ready held high; checks latency, RUN-phase hold and result.
  task automatic run_op(input string tag, input vec_t v);
    int edges;
    bit seen;
    bit hold_ok;
    @(negedge clk);
    check({tag, "_in_ready_idle"}, in_ready, 1);
    a = v.a; b = v.b; cin = v.cin;
`ifdef NIBBLE_SERIAL_SUB_EN
    op = v.op;
`endif
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    // Scramble the inputs: the operation must use only what was captured at accept.
    in_valid = 1'b0; a = ~v.a; b = ~v.b; cin = ~v.cin;
    edges = 0; seen = 0; hold_ok = 1;
    while (!seen && edges < 20) begin
      @(negedge clk);
      if (out_valid) seen = 1;
      else begin
        if (sum !== prev_sum || in_ready !== 1'b0) hold_ok = 0;
        @(posedge clk);
        edges++;
      end
    end
    check({tag, "_out_valid_seen"}, seen, 1);
    // NIB edges after the accepting edge = NIB+1 cycles counting the accept cycle.
    check({tag, "_latency_edges"}, edges, NIB);
    check({tag, "_run_hold"}, hold_ok, 1);
    check({tag, "_sum"}, sum, v.exp_sum);
    check({tag, "_cout"}, cout, v.exp_cout);
    prev_sum = v.exp_sum;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_out_valid_drop"}, out_valid, 0);
  endtask

  initial begin
    vec_t v;
    int   edges;
    bit   seen;
    bit   quiet_ok;
    int   rises[3];
    int   nr;
    logic pv;

    add_vec(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0);
    add_vec(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
    add_vec(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);
    add_vec(16'h0F0F, 16'hF0F0, 1'b0, 1'b0, 16'hFFFF, 1'b0);
    add_vec(16'h8000, 16'h8000, 1'b1, 1'b0, 16'h0001, 1'b1);
    add_vec(16'hABCD, 16'h1234, 1'b1, 1'b0, 16'hBE02, 1'b0);
    add_vec(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1);
`ifdef NIBBLE_SERIAL_SUB_EN
    add_vec(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0);
    add_vec(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1);
    add_vec(16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1);
    add_vec(16'h0003, 16'h0004, 1'b1, 1'b0, 16'h0008, 1'b0);
`endif

    // Reset state while rst_n is low.
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;

    foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i]);

    // Consumer stall in DONE, with an in_valid pulse that must be ignored.
    out_ready = 1'b0;
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
`ifdef NIBBLE_SERIAL_SUB_EN
    op = 1'b0;
`endif
    @(posedge clk);
    #1 in_valid = 1'b0;
    seen = 0; edges = 0;
    while (!seen && edges < 20) begin
      @(negedge clk);
      if (out_valid) seen = 1;
      else begin
        @(posedge clk);
        edges++;
      end
    end
    check("stall_out_valid_seen", seen, 1);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stall%0d_out_valid", k), out_valid, 1);
      check($sformatf("stall%0d_sum", k), sum, 16'h2345);
      check($sformatf("stall%0d_cout", k), cout, 0);
      check($sformatf("stall%0d_in_ready", k), in_ready, 0);
      a = 16'hFFFF; b = 16'h0001; cin = 1'b1;
      in_valid = (k == 1);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("stall_still_valid", out_valid, 1);
    @(posedge clk);
    @(negedge clk);
    check("stall_release_in_ready", in_ready, 1);
    check("stall_release_out_valid", out_valid, 0);
    quiet_ok = 1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || sum !== 16'h2345) quiet_ok = 0;
    end
    check("stall_no_phantom_op", quiet_ok, 1);
    prev_sum = 16'h2345;

    // Asynchronous reset two RUN cycles into an operation.
    @(negedge clk);
    a = 16'hABCD; b = 16'h1111; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_rst_out_valid", out_valid, 0);
    check("midrun_rst_in_ready", in_ready, 1);
    check("midrun_rst_sum", sum, 0);
    check("midrun_rst_cout", cout, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    prev_sum = '0;
    v.a = 16'h00FF; v.b = 16'h0001; v.cin = 1'b0; v.op = 1'b0;
    v.exp_sum = 16'h0100; v.exp_cout = 1'b0;
    run_op("after_rst", v);

    // Back-to-back with in_valid and out_ready held high: one result per NIB+2 cycles.
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    nr = 0; pv = 1'b0;
    rises[0] = 0; rises[1] = 0; rises[2] = 0;
    for (int c = 0; c < 40 && nr < 3; c++) begin
      @(negedge clk);
      if (out_valid && !pv) begin
        rises[nr] = c;
        check($sformatf("b2b%0d_sum", nr), sum, 16'h2345);
        nr++;
      end
      pv = out_valid;
    end
    in_valid = 1'b0;
    check("b2b_result_count", nr, 3);
    check("b2b_period_0", rises[1] - rises[0], NIB + 2);
    check("b2b_period_1", rises[2] - rises[1], NIB + 2);
    @(posedge clk);
    @(negedge clk);
    check("b2b_final_in_ready", in_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
